// File: rtl/frame_reader.sv
// Frame reader: fetches CHUNK_WORDS bursts for the display core into a FWFT pixel FIFO.
// Latency: read_next_chunk -> mem_req two cycles later; mem_rvalid -> pix_valid one cycle later.
// Backpressure: a burst is only requested once the FIFO has room for a whole chunk, so beats are never dropped.
module frame_reader #(
    parameter int CHUNK_WORDS = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] base_addr,
    input  logic [15:0] stride,
    input  logic        read_go,
    input  logic        read_next_line,
    input  logic        read_next_chunk,
    input  logic        read_done,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_len,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_pop,
    output logic        underflow,
    output logic        overrun
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] SPACE_LIMIT = (AW+1)'(FIFO_DEPTH - CHUNK_WORDS);
    localparam logic [3:0]  LAST_BEAT   = 4'(CHUNK_WORDS - 1);
    localparam logic [31:0] CHUNK_BYTES = 32'(4 * CHUNK_WORDS);

    logic [2:0]    state_q, state_d;
    logic [31:0]   line_q, line_d, cur_q, cur_d, hold_q, hold_d;
    logic [15:0]   stride_q, stride_d;
    logic [3:0]    beat_q, beat_d;
    logic          pend_q, pend_d, defer_q, defer_d, go_after_q, go_after_d;
    logic          underflow_q, underflow_d, overrun_q, overrun_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic          flush, push, pop, launch;
    logic [31:0]   line_next;

    assign launch    = (state_q == S_ARMED) && pend_q && (count_q <= SPACE_LIMIT);
    assign line_next = line_q + {16'b0, stride_q};

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cur_d      = cur_q;
        stride_d   = stride_q;
        beat_d     = beat_q;
        pend_d     = pend_q;
        defer_d    = defer_q;
        go_after_d = go_after_q;
        overrun_d  = overrun_q;
        flush      = 1'b0;
        push       = 1'b0;

        // A request arriving on the launch cycle takes the slot being freed.
        if (launch) pend_d = 1'b0;
        if (state_q != S_IDLE && read_next_chunk) begin
            if (pend_q && !launch) overrun_d = 1'b1;
            else                   pend_d    = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (read_go) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (read_next_line) begin
                    line_d = line_next;
                    cur_d  = line_next;
                end
                if (launch) state_d = S_REQ;
            end
            S_REQ: begin
                if (read_next_line) defer_d = 1'b1;
                if (mem_ack) begin
                    cur_d   = cur_q + CHUNK_BYTES;
                    beat_d  = 4'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (read_next_line) defer_d = 1'b1;
                if (mem_rvalid) begin
                    push   = 1'b1;
                    beat_d = beat_q + 4'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 4'd0;
                        state_d = S_ARMED;
                        if (defer_q || read_next_line) begin
                            line_d  = line_next;
                            cur_d   = line_next;
                            defer_d = 1'b0;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (read_go) go_after_d = 1'b1;
                if (mem_rvalid) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d     = 4'd0;
                        state_d    = (go_after_q || read_go) ? S_ARMED : S_IDLE;
                        go_after_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // End of frame or restart: any burst already accepted by memory must be drained.
        if (state_q != S_IDLE && (read_done || read_go)) begin
            pend_d  = 1'b0;
            defer_d = 1'b0;
            if (state_q == S_ARMED || (state_q == S_REQ && !mem_ack)) begin
                state_d = read_go ? S_ARMED : S_IDLE;
            end else if (state_q == S_REQ || (state_q == S_DATA && state_d == S_DATA)) begin
                state_d    = S_DRAIN;
                go_after_d = read_go;
                if (state_q == S_REQ) beat_d = 4'd0;
            end else if (state_q == S_DATA) begin
                state_d = read_go ? S_ARMED : S_IDLE;
            end
        end

        if (read_go) begin
            line_d   = base_addr;
            cur_d    = base_addr;
            stride_d = stride;
            flush    = 1'b1;
            push     = 1'b0;
        end
    end

    always_comb begin
        pop         = pix_pop && (count_q != '0) && !flush;
        underflow_d = underflow_q | (pix_pop && (count_q == '0) && !flush);
        hold_d      = pop ? fifo_mem[rd_q] : hold_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        count_d     = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_q] <= mem_rdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            line_q      <= '0;
            cur_q       <= '0;
            stride_q    <= '0;
            beat_q      <= '0;
            pend_q      <= 1'b0;
            defer_q     <= 1'b0;
            go_after_q  <= 1'b0;
            underflow_q <= 1'b0;
            overrun_q   <= 1'b0;
            hold_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            cur_q       <= cur_d;
            stride_q    <= stride_d;
            beat_q      <= beat_d;
            pend_q      <= pend_d;
            defer_q     <= defer_d;
            go_after_q  <= go_after_d;
            underflow_q <= underflow_d;
            overrun_q   <= overrun_d;
            hold_q      <= hold_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
        end
    end

    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = mem_req ? cur_q : 32'h0;
    assign mem_len   = 4'(CHUNK_WORDS);
    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? fifo_mem[rd_q] : hold_q;
    assign underflow = underflow_q;
    assign overrun   = overrun_q;
endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter: CHUNK_WORDS, default 8, 32-bit words per memory burst (power of two, 1..15).
REQ-002 Parameter: FIFO_DEPTH, default 16, pixel FIFO entries (power of two, >= 2*CHUNK_WORDS).
REQ-003 clock  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 base_addr  in  32  frame byte base address, sampled on read_go.
REQ-006 stride  in  16  byte offset between line starts, sampled on read_go.
REQ-007 read_go / read_next_line / read_next_chunk / read_done  in  1 each  single-cycle requests from the display core: frame start, next line, fetch one chunk, frame end.
REQ-008 mem_req  out  1; mem_addr  out  32; mem_len  out  4 (constant CHUNK_WORDS); mem_ack  in  1 (request accepted); mem_rvalid  in  1; mem_rdata  in  32.
REQ-009 pix_data  out  32 (FIFO head, first-word-fall-through); pix_valid  out  1 (FIFO not empty); pix_pop  in  1.
REQ-010 underflow  out  1  sticky; overrun  out  1  sticky (chunk request lost).

Function
REQ-011 States: IDLE, ARMED, REQ, DATA, DRAIN.
REQ-012 IDLE: read_go -> ARMED; line_addr and cur_addr <= base_addr; stride latched; FIFO flushed. Other requests ignored in IDLE.
REQ-013 read_next_chunk in any non-IDLE state sets one pending flag; pending already set -> overrun <= 1, request dropped.
REQ-014 ARMED with pending set and FIFO free entries >= CHUNK_WORDS -> REQ next cycle; pending cleared.
REQ-015 REQ: mem_req=1, mem_addr=cur_addr held stable until mem_ack sampled high; then -> DATA, cur_addr += 4*CHUNK_WORDS (32-bit wrap).
REQ-016 DATA: each mem_rvalid pushes mem_rdata into FIFO; after CHUNK_WORDS beats -> ARMED. Beats are never dropped in DATA.
REQ-017 read_next_line: line_addr <= line_addr + stride; cur_addr <= line_addr + stride; applied immediately in ARMED; in REQ/DATA deferred until burst completes, then applied before next request.
REQ-018 read_next_line and read_next_chunk in same cycle: line update first; that chunk fetches from new line start.
REQ-019 read_done in ARMED -> IDLE; in REQ before ack -> IDLE, mem_req dropped next cycle; in DATA -> DRAIN; pending cleared.
REQ-020 DRAIN: remaining beats of outstanding burst counted and discarded; on last beat -> IDLE.
REQ-021 read_go outside IDLE: acts as read_done then read_go; base_addr/stride resampled; FIFO flushed; outstanding beats discarded via DRAIN, then ARMED.
REQ-022 Latency: read_next_chunk at cycle N with FIFO space in ARMED -> mem_req=1 at N+2; rvalid at cycle M -> pix_valid=1 by M+1.
REQ-023 FIFO: push and pop same cycle allowed at any occupancy; occupancy never exceeds FIFO_DEPTH (guaranteed by REQ-014).
REQ-024 pix_pop while empty: ignored, pix_data unchanged, underflow <= 1.
REQ-025 FIFO flush takes effect the cycle after read_go; a pop in the flush cycle is ignored.

Reset
REQ-026 reset=0 at a clock edge: state IDLE, mem_req=0, mem_addr=0, FIFO empty, pix_valid=0, pix_data=0, pending=0, underflow=0, overrun=0, line_addr=cur_addr=0.
REQ-027 Reset mid-burst: outstanding memory beats after reset release are ignored (IDLE drops rvalid).
REQ-028 Sticky flags clear only on reset.

Verification
REQ-029 base_addr=0x1000, go, 2x next_chunk (each after prior burst), mem acks 1 cycle later -> mem_addr 0x1000 then 0x1020, 16 words popped in order.
REQ-030 stride=0x1400, go, chunk, next_line+chunk same cycle -> second request mem_addr=0x2400.
REQ-031 Pop with FIFO empty after reset -> underflow=1, pix_valid=0, pix_data=0.
REQ-032 read_done after 3 of 8 beats -> DRAIN, 5 beats discarded, FIFO holds 3, then IDLE, mem_req=0.
REQ-033 Three next_chunk pulses while in REQ -> one pending, overrun=1, exactly two bursts issued.
REQ-034 FIFO at 12 of 16, next_chunk -> no mem_req until occupancy <= 8; then request issued.
